// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, line levels and the transmit FSM state encoding.
package uart_pkg;

   localparam int   UART_DATA_BITS  = 8;
   localparam logic UART_IDLE_LEVEL = 1'b1;
   localparam int   UART_BIT_IDX_W  = $clog2(UART_DATA_BITS);

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT_ACK,
      START,
      DATA,
      STOP
   } uart_state_e;

   // Baud counter width; a 2-cycle bit still needs one counter bit.
   function automatic int baud_cnt_width(input int clks_per_bit);
      return (clks_per_bit < 2) ? 1 : $clog2(clks_per_bit);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the last cycle of each bit.
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic count_en,
   input  logic clear,
   output logic tick
);

   localparam int               CNT_W = baud_cnt_width(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (count_en) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end
   end

   assign tick = count_en && !clear && (cnt_q == LAST);

endmodule

// File: rtl/uart_ring_transmitter.sv
// Fetches bytes from the ring buffer with a one-cycle read handshake and sends each as an 8N1 frame.
// Handshake: readEnable is high for one cycle; dataReadAck/dataRead are sampled on the following edge only.
module uart_ring_transmitter
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   output logic                      readEnable,
   input  logic                      dataReadAck,
   input  logic [UART_DATA_BITS-1:0] dataRead,
   output logic                      txd,
   output logic                      busy,
   output logic                      frameDone,
   output uart_state_e               dbg_state
);

   localparam logic [UART_BIT_IDX_W-1:0] LAST_BIT = UART_BIT_IDX_W'(UART_DATA_BITS - 1);

   uart_state_e                state_q;
   uart_state_e                state_d;
   logic [UART_DATA_BITS-1:0]  shift_q;
   logic [UART_DATA_BITS-1:0]  shift_d;
   logic [UART_BIT_IDX_W-1:0]  bit_idx_q;
   logic [UART_BIT_IDX_W-1:0]  bit_idx_d;

   logic baud_en;
   logic baud_clear;
   logic bit_tick;

   uart_baud_tick #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk      (clk),
      .rst_n    (reset),
      .count_en (baud_en),
      .clear    (baud_clear),
      .tick     (bit_tick)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         bit_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_idx_q <= bit_idx_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_idx_d = bit_idx_q;
      case (state_q)
         IDLE: begin
            if (enable) state_d = REQ;
         end
         REQ: begin
            state_d = WAIT_ACK;
         end
         WAIT_ACK: begin
            // No ack means the buffer was empty: drop back without framing anything.
            if (dataReadAck) begin
               shift_d   = dataRead;
               bit_idx_d = '0;
               state_d   = START;
            end else begin
               state_d = IDLE;
            end
         end
         START: begin
            if (bit_tick) state_d = DATA;
         end
         DATA: begin
            if (bit_tick) begin
               shift_d   = {1'b0, shift_q[UART_DATA_BITS-1:1]};
               bit_idx_d = bit_idx_q + 1'b1;
               if (bit_idx_q == LAST_BIT) state_d = STOP;
            end
         end
         STOP: begin
            if (bit_tick) state_d = enable ? REQ : IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      readEnable = 1'b0;
      txd        = UART_IDLE_LEVEL;
      busy       = 1'b1;
      frameDone  = 1'b0;
      baud_en    = 1'b0;
      baud_clear = 1'b1;
      case (state_q)
         IDLE: begin
            busy = 1'b0;
         end
         REQ: begin
            readEnable = 1'b1;
         end
         START: begin
            txd        = ~UART_IDLE_LEVEL;
            baud_en    = 1'b1;
            baud_clear = 1'b0;
         end
         DATA: begin
            txd        = shift_q[0];
            baud_en    = 1'b1;
            baud_clear = 1'b0;
         end
         STOP: begin
            baud_en    = 1'b1;
            baud_clear = 1'b0;
            frameDone  = bit_tick;
         end
         default: begin
            busy = 1'b1;
         end
      endcase
   end

   assign dbg_state = state_q;

   assert property (@(posedge clk) disable iff (!reset) readEnable |=> !readEnable);
   assert property (@(posedge clk) disable iff (!reset) frameDone |-> (txd == UART_IDLE_LEVEL));

endmodule

// File: tb/tb_uart_ring_transmitter.sv
// Bench for uart_ring_transmitter: ring-buffer model feeds bytes, a line monitor decodes every frame
// cycle by cycle and compares it with the bytes the buffer handed out.
module tb_uart_ring_transmitter;
   import uart_pkg::*;

   localparam int C = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        enable = 1'b0;
   logic        dataReadAck = 1'b0;
   logic [7:0]  dataRead = 8'h00;
   logic        readEnable;
   logic        txd;
   logic        busy;
   logic        frameDone;
   uart_state_e dbg_state;

   int n_tests = 0;
   int n_fail = 0;

   logic [7:0] exp_q[$];
   logic [7:0] buf_q[$];
   int         fall_t[$];
   int         cyc = 0;
   int         n_req = 0;
   int         n_empty = 0;
   int         n_frames = 0;
   int         n_aborts = 0;
   int         n_done = 0;
   bit         noise_on = 1'b0;

   uart_ring_transmitter #(.CLKS_PER_BIT(C)) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .readEnable  (readEnable),
      .dataReadAck (dataReadAck),
      .dataRead    (dataRead),
      .txd         (txd),
      .busy        (busy),
      .frameDone   (frameDone),
      .dbg_state   (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: time limit reached, n_frames=%0d", n_frames);
      $fatal(1);
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic wait_frames(input int target, input int budget, input string name);
      int t;
      t = 0;
      while (n_frames < target && t < budget) begin
         tick();
         t++;
      end
      check({name, "_frames_done"}, n_frames >= target, 1);
   endtask

   task automatic wait_fall(input int target, input int budget, input string name);
      int t;
      t = 0;
      while (fall_t.size() < target && t < budget) begin
         tick();
         t++;
      end
      check({name, "_start_seen"}, fall_t.size() >= target, 1);
   endtask

   task automatic pulse_enable();
      enable = 1'b1;
      tick();
      enable = 1'b0;
   endtask

   // ---------------- ring buffer model ----------------
   initial begin : buffer_model
      bit pending;
      pending = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         dataReadAck = 1'b0;
         dataRead    = 8'h00;
         if (!reset) begin
            pending = 1'b0;
         end else if (pending) begin
            pending = 1'b0;
            if (buf_q.size() > 0) begin
               dataReadAck = 1'b1;
               dataRead    = buf_q.pop_front();
               exp_q.push_back(dataRead);
            end else begin
               n_empty++;
            end
         end else if (noise_on && $urandom_range(0, 1) == 1) begin
            dataReadAck = 1'b1;
            dataRead    = 8'hFF;
         end
         if (reset && readEnable === 1'b1) begin
            pending = 1'b1;
            n_req++;
         end
      end
   end

   // ---------------- line monitor / scoreboard ----------------
   initial begin : frame_done_counter
      forever begin
         @(posedge clk);
         #1;
         if (frameDone === 1'b1) n_done++;
      end
   end

   initial begin : monitor
      logic       prev;
      logic [9:0] bits;
      logic [7:0] b;
      logic       lvl;
      bit         aborted;
      bit         done_ok;
      prev = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (reset && prev === 1'b1 && txd === 1'b0) begin
            fall_t.push_back(cyc);
            if (exp_q.size() == 0) begin
               check("frame_has_fetched_byte", 0, 1);
               b = 8'h00;
            end else begin
               b = exp_q.pop_front();
            end
            bits    = {1'b1, b, 1'b0};
            aborted = 1'b0;
            done_ok = 1'b1;
            for (int k = 0; k < 10 && !aborted; k++) begin
               lvl = bits[k];
               for (int c = 0; c < C; c++) begin
                  if (k != 0 || c != 0) begin
                     @(posedge clk);
                     #1;
                  end
                  if (!reset) begin
                     aborted = 1'b1;
                     break;
                  end
                  if (txd !== bits[k]) lvl = txd;
                  if (frameDone !== ((k == 9 && c == C - 1) ? 1'b1 : 1'b0)) done_ok = 1'b0;
               end
               if (!aborted) check($sformatf("frame_%02h_bit%0d", b, k), lvl, bits[k]);
            end
            if (aborted) begin
               n_aborts++;
            end else begin
               check($sformatf("frame_%02h_framedone_pos", b), done_ok, 1);
               n_frames++;
            end
         end
         prev = txd;
      end
   end

   // ---------------- stimulus ----------------
   initial begin : stimulus
      int r0, d0, f0, e0, a0, nf0, cyc_e, t;
      int pulses, last, gaps_bad;
      bit txd_hi;
      logic [7:0] rb;
      int k;

      // reset values, both during and after reset
      tick(2);
      check("rst_low_readEnable", readEnable, 0);
      check("rst_low_txd", txd, 1);
      check("rst_low_busy", busy, 0);
      check("rst_low_frameDone", frameDone, 0);
      reset = 1'b1;
      tick(2);
      check("rst_state", dbg_state, IDLE);
      check("rst_txd", txd, 1);
      check("rst_busy", busy, 0);

      // single byte 0xA5, enable pulsed once
      buf_q.push_back(8'hA5);
      r0 = n_req; d0 = n_done; f0 = n_frames; nf0 = fall_t.size();
      cyc_e = cyc;
      pulse_enable();
      wait_frames(f0 + 1, 80, "a5");
      tick(3);
      check("a5_read_pulses", n_req - r0, 1);
      check("a5_framedone_count", n_done - d0, 1);
      check("a5_busy_after", busy, 0);
      if (fall_t.size() > nf0) check("a5_start_latency", fall_t[nf0] - cyc_e, 3);

      // empty buffer, enable held 30 cycles
      r0 = n_req; d0 = n_done; e0 = n_empty;
      pulses = 0; last = -1; gaps_bad = 0; txd_hi = 1'b1;
      enable = 1'b1;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (readEnable === 1'b1) begin
            if (last >= 0 && i - last != 3) gaps_bad++;
            last = i;
            pulses++;
         end
         if (txd !== 1'b1) txd_hi = 1'b0;
      end
      enable = 1'b0;
      tick(3);
      check("empty_pulse_count", pulses, 10);
      check("empty_pulse_gaps_bad", gaps_bad, 0);
      check("empty_txd_high", txd_hi, 1);
      check("empty_no_framedone", n_done - d0, 0);
      check("empty_nack_count", n_empty - e0, 10);
      check("empty_busy_after", busy, 0);

      // three bytes back to back, then an empty fetch
      buf_q.push_back(8'h01); buf_q.push_back(8'h02); buf_q.push_back(8'h03);
      r0 = n_req; e0 = n_empty; f0 = n_frames; nf0 = fall_t.size();
      enable = 1'b1;
      wait_frames(f0 + 3, 200, "seq");
      t = 0;
      while (n_req < r0 + 4 && t < 20) begin
         tick();
         t++;
      end
      enable = 1'b0;
      check("seq_requests", n_req - r0, 4);
      tick(4);
      check("seq_empty_fetch", n_empty - e0, 1);
      check("seq_idle_state", dbg_state, IDLE);
      check("seq_busy_after", busy, 0);
      if (fall_t.size() >= nf0 + 3) begin
         check("seq_gap_1_2", fall_t[nf0 + 1] - fall_t[nf0], 10 * C + 2);
         check("seq_gap_2_3", fall_t[nf0 + 2] - fall_t[nf0 + 1], 10 * C + 2);
      end

      // enable dropped during DATA of 0x3C; a further byte waits in the buffer
      buf_q.push_back(8'h3C); buf_q.push_back(8'h77);
      r0 = n_req; d0 = n_done; f0 = n_frames; nf0 = fall_t.size();
      enable = 1'b1;
      wait_fall(nf0 + 1, 20, "drop");
      tick(3 * C);
      enable = 1'b0;
      wait_frames(f0 + 1, 60, "drop");
      tick(10);
      check("drop_requests", n_req - r0, 1);
      check("drop_framedone", n_done - d0, 1);
      check("drop_busy_after", busy, 0);
      check("drop_buffer_left", buf_q.size(), 1);

      // reset during DATA bit 3 of 0x77, then 0x5A goes out cleanly
      buf_q.push_back(8'h5A);
      f0 = n_frames; a0 = n_aborts; nf0 = fall_t.size();
      pulse_enable();
      wait_fall(nf0 + 1, 20, "rst");
      tick(4 * C + 1);
      @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      check("rst_mid_txd", txd, 1);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_readEnable", readEnable, 0);
      check("rst_mid_frameDone", frameDone, 0);
      @(posedge clk);
      #3;
      reset = 1'b1;
      tick(2);
      check("rst_frame_lost", n_aborts - a0, 1);
      check("rst_release_state", dbg_state, IDLE);
      pulse_enable();
      wait_frames(f0 + 1, 80, "rst_next");
      tick(3);

      // spurious acks with 0xFF while the frame is on the line
      buf_q.push_back(8'hC3);
      f0 = n_frames;
      noise_on = 1'b1;
      pulse_enable();
      wait_frames(f0 + 1, 80, "noise");
      noise_on = 1'b0;
      tick(3);

      // randomized traffic with a wandering enable
      for (int it = 0; it < 8; it++) begin
         k  = $urandom_range(1, 4);
         f0 = n_frames;
         for (int j = 0; j < k; j++) begin
            rb = 8'($urandom_range(0, 255));
            buf_q.push_back(rb);
         end
         noise_on = ($urandom_range(0, 1) == 1);
         t = 0;
         while (!(buf_q.size() == 0 && exp_q.size() == 0 && busy === 1'b0) && t < 1500) begin
            enable = ($urandom_range(0, 3) != 0);
            tick();
            t++;
         end
         enable = 1'b0;
         noise_on = 1'b0;
         tick(4);
         check($sformatf("rand%0d_frames", it), n_frames - f0, k);
         check($sformatf("rand%0d_idle", it), busy, 0);
      end

      check("end_exp_q_empty", exp_q.size(), 0);
      check("end_buffer_empty", buf_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
